// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the shared 10-bit bus datapath.
// State table: IDLE | waiting for Run ; T1..T3 | instruction steps, Done on the last one.
module control_sequencer #(
    parameter int NREG = 8,
    parameter int W    = 10
) (
    input  logic            CLKb,
    input  logic            Clear,
    input  logic            Run,
    input  logic [W-1:0]    INSTR,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [3:0]      FN,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            ExtOut,
    output logic            ImmOut,
    output logic [W-1:0]    IMM,
    output logic            Busy,
    output logic            Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0001;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_FLP  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;
    localparam logic [3:0] OP_LDI  = 4'b1110;
    localparam logic [3:0] OP_RSV  = 4'b1111;

    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_ir;

    logic [3:0]     w_op;
    logic [2:0]     w_rx;
    logic [2:0]     w_ry;
    logic [NREG-1:0] w_rx_hot;
    logic [NREG-1:0] w_ry_hot;
    logic [1:0]     w_nsteps;

    assign w_op     = r_ir[W-1:W-4];
    assign w_rx     = r_ir[5:3];
    assign w_ry     = r_ir[2:0];
    assign w_rx_hot = ONE_HOT0 << w_rx;
    assign w_ry_hot = ONE_HOT0 << w_ry;
    assign IMM      = {{(W-3){1'b0}}, r_ir[2:0]};
    assign Busy     = (r_state != S_IDLE);

    always_comb begin
        w_nsteps = 2'd3;
        case (w_op)
            OP_LOAD, OP_COPY, OP_LDI, OP_RSV: w_nsteps = 2'd1;
            OP_INV, OP_FLP:                   w_nsteps = 2'd2;
            default:                          w_nsteps = 2'd3;
        endcase
    end

    always_ff @(posedge CLKb) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && Run)
                r_ir <= INSTR;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = Run ? S_T1 : S_IDLE;
            S_T1:    w_state_nxt = (w_nsteps == 2'd1) ? S_IDLE : S_T2;
            S_T2:    w_state_nxt = (w_nsteps == 2'd2) ? S_IDLE : S_T3;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        FN     = 4'b0000;
        Rin    = '0;
        Rout   = '0;
        ExtOut = 1'b0;
        ImmOut = 1'b0;
        Done   = 1'b0;
        case (r_state)
            S_T1: begin
                Done = (w_nsteps == 2'd1);
                case (w_op)
                    OP_LOAD: begin
                        ExtOut = 1'b1;
                        Rin    = w_rx_hot;
                    end
                    OP_COPY: begin
                        Rout = w_ry_hot;
                        Rin  = w_rx_hot;
                    end
                    OP_INV, OP_FLP: begin
                        Rout = w_ry_hot;
                        Gin  = 1'b1;
                        FN   = w_op;
                    end
                    OP_LDI: begin
                        ImmOut = 1'b1;
                        Rin    = w_rx_hot;
                    end
                    OP_RSV: ;
                    default: begin
                        Rout = w_rx_hot;
                        Ain  = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                Done = (w_nsteps == 2'd2);
                case (w_op)
                    OP_INV, OP_FLP: begin
                        Gout = 1'b1;
                        Rin  = w_rx_hot;
                    end
                    // immediate ops reuse the ALU's ADD/SUB with IMM on the bus
                    OP_ADDI, OP_SUBI: begin
                        ImmOut = 1'b1;
                        Gin    = 1'b1;
                        FN     = (w_op == OP_ADDI) ? 4'b0010 : 4'b0011;
                    end
                    default: begin
                        Rout = w_ry_hot;
                        Gin  = 1'b1;
                        FN   = w_op;
                    end
                endcase
            end
            S_T3: begin
                Gout = 1'b1;
                Rin  = w_rx_hot;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: step-level model checked every cycle plus hand-computed step vectors.
module tb_control_sequencer;

    logic        CLKb = 1'b0;
    logic        Clear = 1'b0;
    logic        Run = 1'b0;
    logic [9:0]  INSTR = '0;
    logic        Ain, Gin, Gout, ExtOut, ImmOut, Busy, Done;
    logic [3:0]  FN;
    logic [7:0]  Rin, Rout;
    logic [9:0]  IMM;

    control_sequencer #(.NREG(8), .W(10)) dut (
        .CLKb(CLKb), .Clear(Clear), .Run(Run), .INSTR(INSTR),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .FN(FN),
        .Rin(Rin), .Rout(Rout), .ExtOut(ExtOut), .ImmOut(ImmOut),
        .IMM(IMM), .Busy(Busy), .Done(Done)
    );

    always #5 CLKb = ~CLKb;

    int errors = 0;
    int checks = 0;

    int         m_step = 0;
    logic [9:0] m_ir = '0;
    logic       chk_en = 1'b0;
    logic       lit_en = 1'b0;
    logic [36:0] lit_exp = '0;
    string      lit_name = "";

    logic [36:0] w_act;
    assign w_act = {Ain, Gin, Gout, FN, Rin, Rout, ExtOut, ImmOut, IMM, Busy, Done};

    function automatic logic [36:0] pk(input logic ain, input logic gin, input logic gout,
                                       input logic [3:0] fn, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ext, input logic immo,
                                       input logic [9:0] imm, input logic busy, input logic done);
        return {ain, gin, gout, fn, rin, rout, ext, immo, imm, busy, done};
    endfunction

    function automatic int n_steps(input logic [3:0] op);
        if (op == 4'd0 || op == 4'd1 || op == 4'd14 || op == 4'd15) return 1;
        if (op == 4'd4 || op == 4'd5) return 2;
        return 3;
    endfunction

    function automatic logic [36:0] model_out(input int step, input logic [9:0] ir);
        logic [3:0] op;
        logic [7:0] rx, ry;
        logic ain, gin, gout, ext, immo;
        logic [3:0] fn;
        logic [7:0] rin, rout;
        op = ir[9:6];
        rx = 8'd1 << ir[5:3];
        ry = 8'd1 << ir[2:0];
        ain = 0; gin = 0; gout = 0; ext = 0; immo = 0; fn = 0; rin = 0; rout = 0;
        if (step == 0) begin
        end else if (op == 4'd0) begin
            ext = 1; rin = rx;
        end else if (op == 4'd1) begin
            rout = ry; rin = rx;
        end else if (op == 4'd14) begin
            immo = 1; rin = rx;
        end else if (op == 4'd15) begin
        end else if (op == 4'd4 || op == 4'd5) begin
            if (step == 1) begin rout = ry; gin = 1; fn = op; end
            else begin gout = 1; rin = rx; end
        end else begin
            if (step == 1) begin
                rout = rx; ain = 1;
            end else if (step == 2) begin
                gin = 1;
                if (op == 4'd12) begin immo = 1; fn = 4'd2; end
                else if (op == 4'd13) begin immo = 1; fn = 4'd3; end
                else begin rout = ry; fn = op; end
            end else begin
                gout = 1; rin = rx;
            end
        end
        return pk(ain, gin, gout, fn, rin, rout, ext, immo, {7'd0, ir[2:0]},
                  step != 0, step != 0 && step == n_steps(op));
    endfunction

    always @(posedge CLKb) begin
        if (Clear) begin
            m_step = 0;
            m_ir   = '0;
        end else if (m_step == 0) begin
            if (Run) begin
                m_ir   = INSTR;
                m_step = 1;
            end
        end else if (m_step == n_steps(m_ir[9:6])) begin
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
    end

    always @(negedge CLKb) begin
        if (chk_en) begin
            logic [36:0] exp_v;
            int drivers;
            exp_v = model_out(m_step, m_ir);
            checks++;
            if (w_act !== exp_v) begin
                errors++;
                $display("FAIL model step=%0d ir=%b actual=%h required=%h", m_step, m_ir, w_act, exp_v);
            end
            drivers = $countones(Rout) + int'(Gout) + int'(ExtOut) + int'(ImmOut);
            checks++;
            if (drivers > 1 || $countones(Rin) > 1 || $countones(Rout) > 1) begin
                errors++;
                $display("FAIL bus_rule drivers=%0d Rin=%b Rout=%b required at most one each", drivers, Rin, Rout);
            end
            if (lit_en) begin
                checks++;
                if (w_act !== lit_exp) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", lit_name, w_act, lit_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic expect_lit(input string nm, input logic [36:0] v);
        lit_name = nm;
        lit_exp  = v;
        lit_en   = 1'b1;
        @(negedge CLKb);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic start(input logic [9:0] ins);
        INSTR = ins;
        Run   = 1'b1;
        tick();
        Run   = 1'b0;
    endtask

    localparam logic [36:0] ZERO = 37'd0;

    initial begin
        Clear = 1'b1;
        tick();
        tick();
        Clear  = 1'b0;
        chk_en = 1'b1;
        tick();
        expect_lit("reset_idle", ZERO);

        start(10'b0000_010_000);
        expect_lit("load_t1", pk(0,0,0,4'd0,8'h04,8'h00,1,0,10'd0,1,1));
        tick();
        expect_lit("load_idle", ZERO);

        start(10'b0010_001_010);
        expect_lit("add_t1", pk(1,0,0,4'd0,8'h00,8'h02,0,0,10'd2,1,0));
        tick();
        expect_lit("add_t2", pk(0,1,0,4'd2,8'h00,8'h04,0,0,10'd2,1,0));
        tick();
        expect_lit("add_t3", pk(0,0,1,4'd0,8'h02,8'h00,0,0,10'd2,1,1));
        tick();
        expect_lit("add_idle", pk(0,0,0,4'd0,8'h00,8'h00,0,0,10'd2,0,0));

        start(10'b1100_101_111);
        expect_lit("addi_t1", pk(1,0,0,4'd0,8'h00,8'h20,0,0,10'd7,1,0));
        tick();
        expect_lit("addi_t2", pk(0,1,0,4'd2,8'h00,8'h00,0,1,10'd7,1,0));
        tick();
        expect_lit("addi_t3", pk(0,0,1,4'd0,8'h20,8'h00,0,0,10'd7,1,1));
        tick();

        start(10'b1101_101_111);
        tick();
        expect_lit("subi_t2", pk(0,1,0,4'd3,8'h00,8'h00,0,1,10'd7,1,0));
        tick();
        tick();

        start(10'b0100_000_110);
        expect_lit("inv_t1", pk(0,1,0,4'd4,8'h00,8'h40,0,0,10'd6,1,0));
        tick();
        expect_lit("inv_t2", pk(0,0,1,4'd0,8'h01,8'h00,0,0,10'd6,1,1));
        tick();

        // SUB R3,R4 with Run and INSTR disturbed while busy
        start(10'b0011_011_100);
        expect_lit("sub_t1", pk(1,0,0,4'd0,8'h00,8'h08,0,0,10'd4,1,0));
        INSTR = 10'b1111_000_000;
        Run   = 1'b1;
        tick();
        expect_lit("sub_t2", pk(0,1,0,4'd3,8'h00,8'h10,0,0,10'd4,1,0));
        Run = 1'b0;
        INSTR = 10'b0000_111_111;
        tick();
        expect_lit("sub_t3", pk(0,0,1,4'd0,8'h08,8'h00,0,0,10'd4,1,1));
        tick();
        expect_lit("sub_idle", pk(0,0,0,4'd0,8'h00,8'h00,0,0,10'd4,0,0));

        start(10'b1111_010_011);
        expect_lit("rsv_t1", pk(0,0,0,4'd0,8'h00,8'h00,0,0,10'd3,1,1));
        tick();
        expect_lit("rsv_idle", pk(0,0,0,4'd0,8'h00,8'h00,0,0,10'd3,0,0));

        // AND R2,R1 aborted by Clear in T2
        start(10'b0110_010_001);
        expect_lit("and_t1", pk(1,0,0,4'd0,8'h00,8'h04,0,0,10'd1,1,0));
        tick();
        expect_lit("and_t2", pk(0,1,0,4'd6,8'h00,8'h02,0,0,10'd1,1,0));
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        expect_lit("abort_idle", ZERO);
        tick();
        expect_lit("abort_idle2", ZERO);

        Clear = 1'b1;
        Run   = 1'b1;
        INSTR = 10'b0000_001_000;
        tick();
        Clear = 1'b0;
        Run   = 1'b0;
        expect_lit("clear_run_idle", ZERO);
        tick();
        expect_lit("clear_run_idle2", ZERO);

        // Rx == Ry, then LDI with Run held to get back-to-back accepts
        start(10'b0010_011_011);
        tick();
        expect_lit("add_r3r3_t2", pk(0,1,0,4'd2,8'h00,8'h08,0,0,10'd3,1,0));
        tick();
        tick();
        INSTR = 10'b1110_110_101;
        Run   = 1'b1;
        tick();
        expect_lit("ldi_t1", pk(0,0,0,4'd0,8'h40,8'h00,0,1,10'd5,1,1));
        tick();
        expect_lit("ldi_gap", pk(0,0,0,4'd0,8'h00,8'h00,0,0,10'd5,0,0));
        tick();
        Run = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            Run   = ($urandom_range(0, 2) != 0);
            INSTR = 10'($urandom);
            Clear = ($urandom_range(0, 19) == 0);
            tick();
        end
        Clear = 1'b0;
        Run   = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle instruction sequencer that drives the shared 10-bit bus datapath: it latches one instruction, then issues per-step register enables, bus-drive enables and ALU controls (Ain, Gin, Gout, FN) to the ALU/accumulator block and the eight general registers. It is the initiating end of the ALU control interface. The ALU and registers only respond to these strobes.

## Interface
Parameters:
- NREG, 8: number of general registers. Width of Rin/Rout; the Rx/Ry fields are 3 bits.
- W, 10: bus and instruction width.

Ports:
- CLKb  in  1  clock; all state updates on the rising edge.
- Clear  in  1  reset; synchronous, active-high.
- Run  in  1  start request, sampled only in IDLE.
- INSTR  in  W  instruction word, captured on accepted Run. Fields: [9:6] opcode, [5:3] Rx, [2:0] Ry.
- Ain  out  1  load ALU A register from bus.
- Gin  out  1  load ALU G register from the ALU result.
- Gout  out  1  G drives bus.
- FN  out  4  ALU function. Encoding: 0000 LOAD, 0001 COPY, 0010 ADD, 0011 SUB, 0100 INV, 0101 FLP, 0110 AND, 0111 OR, 1000 XOR, 1001 LSL, 1010 LSR, 1011 ASR.
- Rin  out  NREG  one-hot register load enables.
- Rout  out  NREG  one-hot register bus-drive enables.
- ExtOut  out  1  external data input drives bus.
- ImmOut  out  1  IMM drives bus.
- IMM  out  W  zero-extended Ry field, {7'b0, IR[2:0]}; valid whenever IR is held.
- Busy  out  1  state != IDLE.
- Done  out  1  high for exactly the final step of each instruction.

## Operation
- Internal IR (10 bits) is loaded from INSTR on the edge where state==IDLE and Run==1. The next state is T1.
- Outputs are combinational decodes of state and IR. Every enable not listed for a step is 0. FN is 0000 except in steps that list it.
- Opcode 0000 LOAD: T1: ExtOut, Rin[Rx], Done.
- Opcode 0001 COPY: T1: Rout[Ry], Rin[Rx], Done.
- Binary opcodes 0010, 0011, 0110–1011:
  - T1: Rout[Rx], Ain.
  - T2: Rout[Ry], Gin, FN=opcode.
  - T3: Gout, Rin[Rx], Done.
- Unary opcodes 0100 INV and 0101 FLP (operand taken from bus, A unused):
  - T1: Rout[Ry], Gin, FN=opcode.
  - T2: Gout, Rin[Rx], Done.
- Immediate opcodes 1100 ADDI and 1101 SUBI:
  - T1: Rout[Rx], Ain.
  - T2: ImmOut, Gin, FN=0010 for ADDI or 0011 for SUBI.
  - T3: Gout, Rin[Rx], Done.
- Opcode 1110 LDI: T1: ImmOut, Rin[Rx], Done.
- Opcode 1111 (reserved): T1: Done only. No enables, no state change elsewhere.
- After the Done step, next state is IDLE.
- Rx == Ry is legal and is sequenced identically (e.g. ADD R3,R3 doubles R3).
- Bus rule: at most one of {any Rout bit, Gout, ExtOut, ImmOut} is high in any cycle.
- Rin and Rout each have at most one bit set.

## Timing
- States: IDLE, T1, T2, T3.
- Latency from the Run-accept edge to Done: 1 cycle for LOAD, COPY, LDI and reserved; 2 cycles for INV and FLP; 3 cycles for binary, ADDI and SUBI.
- Run while Busy is ignored and not queued. The earliest next accept is the edge after the Done cycle, giving 1 idle cycle between instructions.
- INSTR changes while Busy have no effect; IR is held.
- Clear (sync) forces, on that edge:
  - state=IDLE and IR=0;
  - all outputs 0, including FN=0000, IMM=0, Busy=0, Done=0.
- Clear has priority over Run on the same edge.
- Clear mid-instruction aborts it: no further Rin or Gin is issued. A Rin already applied on earlier edges is not undone.

## Test plan
- Clear held 2 cycles, then released → all outputs 0, Busy=0. Run with INSTR=0000_010_000 → next cycle ExtOut=1, Rin=8'b0000_0100, Done=1; then Busy=0.
- ADD R1,R2 (0010_001_010): 3 steps → {Rout=02, Ain}, {Rout=04, Gin, FN=0010}, {Gout, Rin=02, Done}. Exactly one bus driver each cycle.
- ADDI R5,#7 (1100_101_111) → IMM=10'd7. Steps: {Rout=20, Ain}, {ImmOut, Gin, FN=0010}, {Gout, Rin=20, Done}. SUBI gives FN=0011 in T2.
- INV R0,R6 (0100_000_110) → {Rout=40, Gin, FN=0100}, {Gout, Rin=01, Done}; Ain never asserted.
- Run toggled and INSTR changed during a SUB → ignored, sequence unchanged. Reserved 1111_xxx_xxx → single Done cycle with all enables 0.
- Clear asserted in T2 of an AND → next cycle IDLE with all outputs 0, Rin never asserted. Clear and Run high on the same edge → stays IDLE.
